// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction from execute, captures and
// aligns load data, and drives the writeback, stall and forward buses.
module mem_stage #(
   parameter int ES_TO_MS_BUS_WD = 93,
   parameter int MS_TO_WS_BUS_WD = 83
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   input  logic                       ms_flush,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [9:0]                 stall_ms_bus,
   output logic [32:0]                forward_ms_bus,
   input  logic [31:0]                data_sram_rdata
);

   logic                       ms_valid;
   logic                       ms_first;
   logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
   logic [31:0]                rdata_buf;

   logic        cp0_wen;
   logic        res_from_cp0;
   logic [7:0]  cp0_addr;
   logic        res_from_mem;
   logic [6:0]  inst_load;
   logic [4:0]  ld_extd_op;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;

   logic [1:0]  addr_lo;
   logic [31:0] mem_w;
   logic [7:0]  mem_byte;
   logic [15:0] mem_half;
   logic [31:0] load_result;
   logic [3:0]  load_strb;
   logic [31:0] final_result;
   logic [3:0]  rf_strb;
   logic        fwd_valid;
   logic        unused_ld_extd_op;

   assign {cp0_wen, res_from_cp0, cp0_addr, res_from_mem, inst_load, ld_extd_op,
           gr_we, dest, alu_result, pc} = ms_bus_r;

   assign unused_ld_extd_op = ^ld_extd_op;

   assign ms_allowin     = !ms_valid | ws_allowin;
   assign ms_to_ws_valid = ms_valid & ~ms_flush;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid  <= 1'b0;
         ms_first  <= 1'b0;
         ms_bus_r  <= '0;
         rdata_buf <= 32'h0;
      end else begin
         if (ms_flush) begin
            ms_valid <= 1'b0;
         end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
         end
         // The bus is still loaded on a flushed accept; ms_valid alone kills it.
         if (es_to_ms_valid && ms_allowin) begin
            ms_bus_r <= es_to_ms_bus;
            ms_first <= 1'b1;
         end else begin
            ms_first <= 1'b0;
         end
         if (ms_first) begin
            rdata_buf <= data_sram_rdata;
         end
      end
   end

   // SRAM data is only valid in the first cycle; later cycles replay the buffered copy.
   assign mem_w   = ms_first ? data_sram_rdata : rdata_buf;
   assign addr_lo = alu_result[1:0];

   always_comb begin
      mem_byte = 8'h0;
      unique case (addr_lo)
         2'd0: mem_byte = mem_w[7:0];
         2'd1: mem_byte = mem_w[15:8];
         2'd2: mem_byte = mem_w[23:16];
         2'd3: mem_byte = mem_w[31:24];
      endcase
      mem_half = addr_lo[1] ? mem_w[31:16] : mem_w[15:0];

      load_result = mem_w;
      load_strb   = 4'b1111;
      if (inst_load[0]) begin
         load_result = {{24{mem_byte[7]}}, mem_byte};
      end else if (inst_load[1]) begin
         load_result = {24'h0, mem_byte};
      end else if (inst_load[2]) begin
         load_result = {{16{mem_half[15]}}, mem_half};
      end else if (inst_load[3]) begin
         load_result = {16'h0, mem_half};
      end else if (inst_load[4]) begin
         load_result = mem_w;
      end else if (inst_load[5]) begin
         unique case (addr_lo)
            2'd0: begin load_result = {mem_w[7:0], 24'h0};  load_strb = 4'b1000; end
            2'd1: begin load_result = {mem_w[15:0], 16'h0}; load_strb = 4'b1100; end
            2'd2: begin load_result = {mem_w[23:0], 8'h0};  load_strb = 4'b1110; end
            2'd3: begin load_result = mem_w;                load_strb = 4'b1111; end
         endcase
      end else if (inst_load[6]) begin
         unique case (addr_lo)
            2'd0: begin load_result = mem_w;                load_strb = 4'b1111; end
            2'd1: begin load_result = {8'h0, mem_w[31:8]};  load_strb = 4'b0111; end
            2'd2: begin load_result = {16'h0, mem_w[31:16]}; load_strb = 4'b0011; end
            2'd3: begin load_result = {24'h0, mem_w[31:24]}; load_strb = 4'b0001; end
         endcase
      end
   end

   assign final_result = res_from_mem ? load_result : alu_result;
   assign rf_strb      = res_from_mem ? load_strb : {4{gr_we}};

   assign ms_to_ws_bus = {cp0_wen, res_from_cp0, cp0_addr, rf_strb, dest, final_result, pc};

   // LWL/LWR merge with the old register value in writeback, so they cannot be forwarded.
   assign fwd_valid      = ms_valid & gr_we & ~res_from_cp0 & ~inst_load[5] & ~inst_load[6];
   assign forward_ms_bus = {fwd_valid, final_result};
   assign stall_ms_bus   = {{5{ms_valid & gr_we}}, dest};

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed literal cases plus randomized traffic checked every
// cycle against an instruction-slot reference model.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        resetn;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [92:0] es_to_ms_bus;
   logic        ms_flush;
   logic        ms_to_ws_valid;
   logic [82:0] ms_to_ws_bus;
   logic [9:0]  stall_ms_bus;
   logic [32:0] forward_ms_bus;
   logic [31:0] data_sram_rdata;

   int checks = 0;
   int failures = 0;

   mem_stage #(
      .ES_TO_MS_BUS_WD(93),
      .MS_TO_WS_BUS_WD(83)
   ) dut (
      .clk             (clk),
      .resetn          (resetn),
      .ws_allowin      (ws_allowin),
      .ms_allowin      (ms_allowin),
      .es_to_ms_valid  (es_to_ms_valid),
      .es_to_ms_bus    (es_to_ms_bus),
      .ms_flush        (ms_flush),
      .ms_to_ws_valid  (ms_to_ws_valid),
      .ms_to_ws_bus    (ms_to_ws_bus),
      .stall_ms_bus    (stall_ms_bus),
      .forward_ms_bus  (forward_ms_bus),
      .data_sram_rdata (data_sram_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [82:0] act, input logic [82:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [92:0] mk(input logic cw, input logic rc, input logic [7:0] ca,
                                      input logic rm, input logic [6:0] il, input logic gw,
                                      input logic [4:0] d, input logic [31:0] alu,
                                      input logic [31:0] pc);
      return {cw, rc, ca, rm, il, 5'b0, gw, d, alu, pc};
   endfunction

   // Returns {rf_strb, final_result} for an instruction given its loaded word.
   function automatic logic [35:0] expect_res(input logic [92:0] b, input logic [31:0] w);
      logic [31:0] alu;
      logic [6:0]  il;
      int          a;
      logic [7:0]  by;
      logic [15:0] hw;
      alu = b[63:32];
      il  = b[81:75];
      a   = int'(alu[1:0]);
      by  = 8'((w >> (8 * a)) & 32'hff);
      hw  = alu[1] ? w[31:16] : w[15:0];
      if (!b[82]) return {{4{b[69]}}, alu};
      if (il[0]) return {4'hf, 32'($signed(by))};
      if (il[1]) return {4'hf, 24'h0, by};
      if (il[2]) return {4'hf, 32'($signed(hw))};
      if (il[3]) return {4'hf, 16'h0, hw};
      if (il[5]) return {4'(4'b1111 << (3 - a)), w << (8 * (3 - a))};
      if (il[6]) return {4'(4'b1111 >> a), w >> (8 * a)};
      return {4'hf, w};
   endfunction

   // Reference model: one instruction slot plus the load word that belongs to it.
   logic        m_valid;
   logic [92:0] m_instr;
   logic        m_word_live;
   logic [31:0] m_word;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_valid     <= 1'b0;
         m_instr     <= '0;
         m_word_live <= 1'b0;
         m_word      <= 32'h0;
      end else begin
         if (m_word_live) m_word <= data_sram_rdata;
         m_word_live <= es_to_ms_valid && (!m_valid || ws_allowin);
         if (es_to_ms_valid && (!m_valid || ws_allowin)) m_instr <= es_to_ms_bus;
         if (ms_flush) m_valid <= 1'b0;
         else if (!m_valid || ws_allowin) m_valid <= es_to_ms_valid;
      end
   end

   always @(negedge clk) begin
      if (resetn) begin
         logic [35:0] r;
         logic        fwd;
         r   = expect_res(m_instr, m_word_live ? data_sram_rdata : m_word);
         fwd = m_valid & m_instr[69] & ~m_instr[91] & ~m_instr[80] & ~m_instr[81];
         chk("allowin", 83'(ms_allowin), 83'(!m_valid || ws_allowin));
         chk("ws_valid", 83'(ms_to_ws_valid), 83'(m_valid && !ms_flush));
         chk("ws_bus", ms_to_ws_bus,
             {m_instr[92:83], r[35:32], m_instr[68:64], r[31:0], m_instr[31:0]});
         chk("stall_bus", 83'(stall_ms_bus), 83'({{5{m_valid & m_instr[69]}}, m_instr[68:64]}));
         chk("fwd_bus", 83'(forward_ms_bus), 83'({fwd, r[31:0]}));
      end
   end

   // Accept one load, present its SRAM word next cycle and check the aligned result.
   task automatic load_check(input string name, input logic [92:0] b, input logic [31:0] rd,
                             input logic [31:0] exp_res, input logic [3:0] exp_strb,
                             input logic exp_fwd);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = b;
      ws_allowin     = 1'b1;
      ms_flush       = 1'b0;
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = rd;
      #2;
      chk({name, "_res"}, 83'(ms_to_ws_bus[63:32]), 83'(exp_res));
      chk({name, "_strb"}, 83'(ms_to_ws_bus[72:69]), 83'(exp_strb));
      chk({name, "_fwd"}, 83'(forward_ms_bus[32]), 83'(exp_fwd));
   endtask

   initial begin
      resetn          = 1'b0;
      ws_allowin      = 1'b1;
      es_to_ms_valid  = 1'b0;
      es_to_ms_bus    = '0;
      ms_flush        = 1'b0;
      data_sram_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      #1;
      chk("rst_allowin", 83'(ms_allowin), 83'(1));
      chk("rst_ws_valid", 83'(ms_to_ws_valid), 83'(0));
      chk("rst_stall", 83'(stall_ms_bus[9:5]), 83'(0));
      chk("rst_fwd", 83'(forward_ms_bus[32]), 83'(0));
      @(posedge clk); #1;

      load_check("lb", mk(0, 0, 8'h0, 1, 7'b0000001, 1, 5'd3, 32'h1002, 32'h40), 32'h1280_7F00,
                 32'hFFFF_FF80, 4'b1111, 1'b1);
      load_check("lbu", mk(0, 0, 8'h0, 1, 7'b0000010, 1, 5'd3, 32'h1002, 32'h44), 32'h1280_7F00,
                 32'h0000_0080, 4'b1111, 1'b1);
      load_check("lh", mk(0, 0, 8'h0, 1, 7'b0000100, 1, 5'd3, 32'h1002, 32'h48), 32'h1280_7F00,
                 32'h0000_1280, 4'b1111, 1'b1);
      load_check("lwl", mk(0, 0, 8'h0, 1, 7'b0100000, 1, 5'd4, 32'h2001, 32'h4c), 32'hAABB_CCDD,
                 32'hCCDD_0000, 4'b1100, 1'b0);
      load_check("lwr", mk(0, 0, 8'h0, 1, 7'b1000000, 1, 5'd4, 32'h2001, 32'h50), 32'hAABB_CCDD,
                 32'h00AA_BBCC, 4'b0111, 1'b0);

      // Stall hold: data must survive SRAM read data changing underneath.
      load_check("lw", mk(0, 0, 8'h0, 1, 7'b0010000, 1, 5'd7, 32'h100, 32'h54), 32'hDEAD_BEEF,
                 32'hDEAD_BEEF, 4'b1111, 1'b1);
      ws_allowin = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         data_sram_rdata = 32'h0;
         #2;
         chk("hold_res", 83'(ms_to_ws_bus[63:32]), 83'(32'hDEAD_BEEF));
         chk("hold_valid", 83'(ms_to_ws_valid), 83'(1));
         chk("hold_allowin", 83'(ms_allowin), 83'(0));
      end
      ws_allowin = 1'b1;
      #1 chk("release_res", 83'(ms_to_ws_bus[63:32]), 83'(32'hDEAD_BEEF));
      @(posedge clk); #1;
      chk("release_empty", 83'(ms_to_ws_valid), 83'(0));

      // Back-to-back ALU op then load.
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(0, 0, 8'h0, 0, 7'b0, 1, 5'd5, 32'd7, 32'h60);
      @(posedge clk); #1;
      es_to_ms_bus = mk(0, 0, 8'h0, 1, 7'b0010000, 1, 5'd6, 32'h200, 32'h64);
      #2 chk("b2b_alu_fwd", 83'(forward_ms_bus), 83'({1'b1, 32'd7}));
      @(posedge clk); #1;
      es_to_ms_valid  = 1'b0;
      data_sram_rdata = 32'h1234_5678;
      #2 chk("b2b_lw_fwd", 83'(forward_ms_bus), 83'({1'b1, 32'h1234_5678}));
      chk("b2b_lw_valid", 83'(ms_to_ws_valid), 83'(1));

      // Flush while holding a stalled load with another instruction offered.
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(0, 0, 8'h0, 1, 7'b0010000, 1, 5'd8, 32'h300, 32'h68);
      @(posedge clk); #1;
      ws_allowin = 1'b0;
      ms_flush   = 1'b1;
      #2 chk("flush_ws_valid", 83'(ms_to_ws_valid), 83'(0));
      @(posedge clk); #1;
      ms_flush       = 1'b0;
      es_to_ms_valid = 1'b0;
      ws_allowin     = 1'b1;
      #2;
      chk("flush_after_valid", 83'(ms_to_ws_valid), 83'(0));
      chk("flush_after_stall", 83'(stall_ms_bus[9:5]), 83'(0));

      // Asynchronous reset with a valid instruction held.
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(0, 0, 8'h0, 0, 7'b0, 1, 5'd9, 32'd1, 32'h70);
      @(posedge clk); #1;
      es_to_ms_valid = 1'b0;
      ws_allowin     = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk("arst_ws_valid", 83'(ms_to_ws_valid), 83'(0));
      chk("arst_allowin", 83'(ms_allowin), 83'(1));
      chk("arst_stall", 83'(stall_ms_bus[9:5]), 83'(0));
      chk("arst_fwd", 83'(forward_ms_bus[32]), 83'(0));
      @(posedge clk); #2 resetn = 1'b1;

      // Randomized traffic; the negedge compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         begin
            logic       rm;
            logic [6:0] il;
            rm = 1'($urandom_range(0, 1));
            il = rm ? 7'(1 << $urandom_range(0, 6)) : 7'b0;
            es_to_ms_valid = ($urandom_range(0, 3) != 0);
            es_to_ms_bus   = mk(1'($urandom), 1'($urandom_range(0, 3) == 0), 8'($urandom), rm,
                                il, rm ? 1'b1 : 1'($urandom), 5'($urandom), $urandom,
                                $urandom);
            ws_allowin      = ($urandom_range(0, 2) != 0);
            ms_flush        = ($urandom_range(0, 15) == 0);
            data_sram_rdata = $urandom;
         end
      end
      @(posedge clk); #1;
      @(negedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
